// File: rtl/control_state_sequencer.sv
// control_state_sequencer: multi-cycle instruction sequencer producing the
// 4-bit STATE code for the PC/RAM decode stage. Includes a memory-ready
// handshake with timeout, halt/resume, a retired-instruction counter and a
// sticky fault state. All flops run on the rising edge of clock-tree bit 4
// and advance only when tick bit 2 is high; reset is synchronous.
module control_state_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic [4:0]           LOGISIM_CLOCK_TREE_0,
  input  logic                 RESET,
  input  logic                 CPU_EN,
  input  logic                 IS_BRANCH,
  input  logic                 BRANCH_TAKEN,
  input  logic                 IS_MEM,
  input  logic                 IS_STORE,
  input  logic                 IS_HALT,
  input  logic                 MEM_READY,
  input  logic                 RESUME,
  output logic [3:0]           STATE,
  output logic                 INSTR_DONE,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT,
  output logic                 HALTED,
  output logic                 FAULT
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'h0,
    S_DECODE     = 4'h1,
    S_EXECUTE    = 4'h2,
    S_BRANCH     = 4'h3,
    S_MEM_SETUP  = 4'h4,
    S_MEM_ACCESS = 4'h5,
    S_MEM_WB     = 4'h6,
    S_HALT       = 4'h8,
    S_FAULT      = 4'hF
  } state_e;

  localparam logic [7:0]           TMO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic clk;
  logic tick;
  logic unused_tree;

  assign clk         = LOGISIM_CLOCK_TREE_0[4];
  assign tick        = LOGISIM_CLOCK_TREE_0[2];
  assign unused_tree = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};

  state_e               state_q, state_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 retire;

  // State register: synchronous reset, advances only on a tick.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_FETCH;
    end else if (tick) begin
      state_q <= state_d;
    end
  end

  // Timeout counter, retirement pulse and retired-instruction count.
  always_ff @(posedge clk) begin
    if (RESET) begin
      tmo_q  <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else if (tick) begin
      tmo_q  <= tmo_d;
      done_q <= retire;
      if (retire) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // Next-state logic; the timeout compare uses the pre-increment count so a
  // limit of N yields exactly N ticks in MEM_ACCESS, and MEM_READY wins.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (CPU_EN) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (IS_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (IS_BRANCH && BRANCH_TAKEN) begin
          state_d = S_BRANCH;
        end else if (IS_MEM) begin
          state_d = S_MEM_SETUP;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE, S_BRANCH, S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_SETUP: begin
        state_d = S_MEM_ACCESS;
        tmo_d   = '0;
      end
      S_MEM_ACCESS: begin
        if (MEM_READY) begin
          if (IS_STORE) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_MEM_WB;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == TMO_LAST) state_d = S_FAULT;
        end
      end
      S_HALT: begin
        if (RESUME) state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    STATE       = state_q;
    HALTED      = (state_q == S_HALT);
    FAULT       = (state_q == S_FAULT);
    INSTR_DONE  = done_q;
    INSTR_COUNT = cnt_q;
  end

endmodule

// File: tb/tb_control_state_sequencer.sv
// Testbench for control_state_sequencer: an instruction-level trace model
// pushes the expected outputs for every clock edge into a queue; a separate
// monitor pops and compares after each rising edge.
module tb_control_state_sequencer;

  localparam int unsigned T  = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          tick = 1'b0;
  logic [4:0]    tree;
  logic          rst, cpu_en, is_branch, br_taken, is_mem, is_store, is_halt;
  logic          mem_ready, resume;
  logic [3:0]    state_o;
  logic          done_o, halted_o, fault_o;
  logic [CW-1:0] count_o;

  assign tree = {clk, 1'b0, tick, 2'b00};

  always #5 clk = ~clk;

  control_state_sequencer #(.MEM_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .LOGISIM_CLOCK_TREE_0(tree),
    .RESET       (rst),
    .CPU_EN      (cpu_en),
    .IS_BRANCH   (is_branch),
    .BRANCH_TAKEN(br_taken),
    .IS_MEM      (is_mem),
    .IS_STORE    (is_store),
    .IS_HALT     (is_halt),
    .MEM_READY   (mem_ready),
    .RESUME      (resume),
    .STATE       (state_o),
    .INSTR_DONE  (done_o),
    .INSTR_COUNT (count_o),
    .HALTED      (halted_o),
    .FAULT       (fault_o)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  m_st = 4'h0;
  logic        m_done = 1'b0;
  int unsigned m_cnt = 0;
  bit          started = 1'b0;
  bit          finished = 1'b0;

  localparam logic [3:0] C_FETCH = 4'h0, C_DEC = 4'h1, C_EXE = 4'h2, C_BR = 4'h3;
  localparam logic [3:0] C_MSET = 4'h4, C_MACC = 4'h5, C_MWB = 4'h6;
  localparam logic [3:0] C_HALT = 4'h8, C_FAULT = 4'hF;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      if (finished) break;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected an entry at t=%0t", $time);
      end else begin
        e = expq.pop_front();
        check("STATE", 16'(state_o), 16'(e.st));
        check("INSTR_DONE", 16'(done_o), 16'(e.done));
        check("INSTR_COUNT", 16'(count_o), 16'(e.cnt));
        check("HALTED", 16'(halted_o), 16'(e.st == C_HALT));
        check("FAULT", 16'(fault_o), 16'(e.st == C_FAULT));
      end
    end
  end

  task automatic push_and_edge();
    expq.push_back(exp_t'{m_st, m_done, CW'(m_cnt)});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Edges with tick low: every output must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b0;
      push_and_edge();
    end
  endtask

  // One tick after which STATE shows `code`; `ret` marks a retirement.
  task automatic tick_to(input logic [3:0] code, input bit ret);
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    m_st   = code;
    m_done = ret;
    if (ret) m_cnt = (m_cnt + 1) % (1 << CW);
    tick = 1'b1;
    push_and_edge();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tick   = 1'($urandom_range(0, 1));
    m_st   = C_FETCH;
    m_done = 1'b0;
    m_cnt  = 0;
    push_and_edge();
    rst  = 1'b0;
    tick = 1'b0;
  endtask

  task automatic fault_and_reset();
    int n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      resume    = 1'($urandom_range(0, 1)) | (i == 0);
      mem_ready = 1'($urandom_range(0, 1));
      cpu_en    = 1'($urandom_range(0, 1));
      tick_to(C_FAULT, 1'b0);
    end
    resume = 1'b0;
    do_reset();
  endtask

  // kind: 0 alu, 1 untaken branch, 2 taken branch, 3 load, 4 store,
  //       5 halt, 6 reset right after decode. lat = MEM_READY-low ticks.
  task automatic run_instr(input int kind, input int waits, input int lat, input int hold);
    bit faulted = 1'b0;
    cpu_en = 1'b0;
    for (int i = 0; i < waits; i++) tick_to(C_FETCH, 1'b0);
    cpu_en    = 1'b1;
    is_halt   = (kind == 5) ? 1'b1 : 1'b0;
    is_branch = 1'($urandom_range(0, 1));
    br_taken  = 1'($urandom_range(0, 1));
    is_mem    = 1'($urandom_range(0, 1));
    is_store  = 1'($urandom_range(0, 1));
    case (kind)
      0: begin is_branch = 1'b0; is_mem = 1'b0; end
      1: begin is_branch = 1'b1; br_taken = 1'b0; is_mem = 1'b0; end
      2: begin is_branch = 1'b1; br_taken = 1'b1; end
      3: begin is_mem = 1'b1; is_store = 1'b0; if (is_branch) br_taken = 1'b0; end
      4: begin is_mem = 1'b1; is_store = 1'b1; if (is_branch) br_taken = 1'b0; end
      default: ;
    endcase
    tick_to(C_DEC, 1'b0);
    cpu_en    = 1'($urandom_range(0, 1));
    resume    = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
    case (kind)
      0, 1: begin tick_to(C_EXE, 1'b0); tick_to(C_FETCH, 1'b1); end
      2:    begin tick_to(C_BR, 1'b0);  tick_to(C_FETCH, 1'b1); end
      3, 4: begin
        tick_to(C_MSET, 1'b0);
        tick_to(C_MACC, 1'b0);
        for (int i = 0; i < lat; i++) begin
          mem_ready = 1'b0;
          if (i == int'(T) - 1) begin
            tick_to(C_FAULT, 1'b0);
            faulted = 1'b1;
            break;
          end
          tick_to(C_MACC, 1'b0);
        end
        if (faulted) begin
          fault_and_reset();
        end else begin
          mem_ready = 1'b1;
          if (kind == 4) begin
            tick_to(C_FETCH, 1'b1);
          end else begin
            tick_to(C_MWB, 1'b0);
            mem_ready = 1'($urandom_range(0, 1));
            tick_to(C_FETCH, 1'b1);
          end
        end
      end
      5: begin
        resume = 1'b0;
        tick_to(C_HALT, 1'b1);
        for (int i = 0; i < hold; i++) begin
          cpu_en = 1'($urandom_range(0, 1));
          tick_to(C_HALT, 1'b0);
          if (i == 2) idle(6);
        end
        resume = 1'b1;
        tick_to(C_FETCH, 1'b0);
        resume = 1'b0;
      end
      default: do_reset();
    endcase
    mem_ready = 1'b0;
    resume    = 1'b0;
  endtask

  // Stimulus: directed scenarios then randomized instruction stream.
  initial begin
    int kind, lat;
    rst = 1'b1; cpu_en = 1'b0; is_branch = 1'b0; br_taken = 1'b0; is_mem = 1'b0;
    is_store = 1'b0; is_halt = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    @(negedge clk);
    started = 1'b1;
    do_reset();
    run_instr(0, 5, 0, 0);
    run_instr(2, 0, 0, 0);
    run_instr(1, 1, 0, 0);
    run_instr(3, 0, 3, 0);
    run_instr(4, 0, 0, 0);
    run_instr(5, 0, 0, 10);
    run_instr(3, 0, 6, 0);
    run_instr(4, 2, int'(T), 0);
    for (int i = 0; i < 17; i++) run_instr(0, 0, 0, 0);
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 19);
      if (kind > 6) kind = kind % 5;
      if (kind == 6 && $urandom_range(0, 1) == 0) kind = 0;
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(int'(T), int'(T) + 2)
                                        : $urandom_range(0, int'(T) - 1);
      run_instr(kind, $urandom_range(0, 2), lat, $urandom_range(0, 4));
    end
    finished = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
